// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and constants for the mux scan sequencer
package mux_scan_pkg;
  localparam int SEL_W = 3;
  localparam int N_CH = 2**SEL_W;
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: request, mux return, select and word handshake bundle; data_parity exists only with MUX_SCAN_PARITY_EN
interface mux_scan_ctrl_if #(parameter int SEL_W = mux_scan_pkg::SEL_W) ();
  logic start;
  logic mux_o;
  logic s1, s2, s3;
  logic busy;
  logic [2**SEL_W-1:0] data;
  logic data_valid;
  logic data_ack;
`ifdef MUX_SCAN_PARITY_EN
  logic data_parity;
  modport master (output start, mux_o, data_ack, input s1, s2, s3, busy, data, data_valid, data_parity);
  modport slave (input start, mux_o, data_ack, output s1, s2, s3, busy, data, data_valid, data_parity);
`else
  modport master (output start, mux_o, data_ack, input s1, s2, s3, busy, data, data_valid);
  modport slave (input start, mux_o, data_ack, output s1, s2, s3, busy, data, data_valid);
`endif
endinterface

// File: rtl/mux_sel_counter.sv
// mux_sel_counter: select counter with synchronous clear, enable and terminal-count flag
module mux_sel_counter
  import mux_scan_pkg::*;
#(parameter int SEL_W = mux_scan_pkg::SEL_W) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [SEL_W-1:0] sel,
  output logic             tc
);
  // step through the channels; clear wins over enable
  always_ff @(posedge clk or posedge rst)
    if (rst) sel <= '0;
    else if (clear) sel <= '0;
    else if (enable) sel <= sel + 1'b1;
  assign tc = &sel;
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps the mux select through all channels and assembles the samples into one word; MUX_SCAN_PARITY_EN adds data_parity
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(parameter int SEL_W = mux_scan_pkg::SEL_W) (
  input logic           clk,
  input logic           rst,
  mux_scan_ctrl_if.slave bus
);
  localparam int n_ch = 2**SEL_W;
  state_t state, state_nx;
  logic [SEL_W-1:0] sel;
  logic tc, cnt_clr, cnt_en, cap, done;
  logic [n_ch-1:0] data_sr, sr_nx;
  mux_sel_counter #(.SEL_W(SEL_W)) u_cnt (
    .clk(clk), .rst(rst), .clear(cnt_clr), .enable(cnt_en), .sel(sel), .tc(tc)
  );
  assign {bus.s1, bus.s2, bus.s3} = sel;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: start only in IDLE, ack only in HOLD (ack wins over a coincident start)
  always_comb
    state_nx = (state == IDLE && bus.start) ? SCAN :
               (state == SCAN && tc)        ? HOLD :
               (state == HOLD && bus.data_ack) ? IDLE : state;
  // outputs: sel holds at the last channel through HOLD and is cleared by the ack
  always_comb begin
    bus.busy = state != IDLE;
    cap = state == SCAN;
    done = cap && tc;
    cnt_en = cap && !tc;
    cnt_clr = state == HOLD && bus.data_ack;
  end
  // shift-in of the current channel's sample
  always_comb begin
    sr_nx = data_sr;
    sr_nx[sel] = bus.mux_o;
  end
  // capture register, one bit per scan cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) data_sr <= '0;
    else if (cap) data_sr <= sr_nx;
  // output word and valid flag; only a completed scan updates data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.data <= '0;
      bus.data_valid <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      bus.data_parity <= 1'b0;
`endif
    end else if (done) begin
      bus.data <= sr_nx;
      bus.data_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
      bus.data_parity <= ^sr_nx;
`endif
    end else if (cnt_clr) bus.data_valid <= 1'b0;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: randomized scoreboard bench for mux_scan_ctrl (parity checks with MUX_SCAN_PARITY_EN)
module tb_mux_scan_ctrl;
  typedef struct {logic [7:0] word; int due;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] mux_in = '0;
  int cyc = 0, checks = 0, errors = 0;
  exp_t sb[$];
  exp_t e;
  logic prev_v = 1'b0;
  logic [7:0] held = '0;
  mux_scan_ctrl_if bus();
  mux_scan_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.mux_o = mux_in[{bus.s1, bus.s2, bus.s3}];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: a rising data_valid pops the scoreboard; while held, data must not move
  always @(negedge clk) begin
    if (rst) prev_v = 1'b0;
    else begin
      if (bus.data_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h with no scan outstanding", bus.data);
        end else begin
          e = sb.pop_front();
          chk("word", bus.data, e.word);
          chk("latency", cyc, e.due);
`ifdef MUX_SCAN_PARITY_EN
          chk("parity", bus.data_parity, ^e.word);
`endif
        end
        held = bus.data;
      end else if (bus.data_valid) chk("hold_stable", bus.data, held);
      prev_v = bus.data_valid;
    end
  end

  task automatic scan(input logic [7:0] vec, input int ack_dly, input bit glitch, input bit ack_start);
    int c;
    @(negedge clk);
    mux_in = vec;
    bus.start = 1'b1;
    sb.push_back('{vec, cyc + 9});
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_rise", bus.busy, 1);
    for (int k = 0; k < 8; k++) begin
      chk("sel_step", {bus.s1, bus.s2, bus.s3}, k);
      bus.start = glitch && k == 3;
      @(negedge clk);
    end
    c = 0;
    while (!bus.data_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (!bus.data_valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: data_valid still 0 after 20 cycles, expected 1");
    end
    repeat (ack_dly) begin
      chk("busy_hold", bus.busy, 1);
      @(negedge clk);
    end
    bus.data_ack = 1'b1;
    bus.start = ack_start;
    @(negedge clk);
    bus.data_ack = 1'b0;
    bus.start = 1'b0;
    chk("valid_after_ack", bus.data_valid, 0);
    chk("busy_after_ack", bus.busy, 0);
    chk("sel_after_ack", {bus.s1, bus.s2, bus.s3}, 0);
    chk("data_kept", bus.data, vec);
    @(negedge clk);
    chk("no_restart", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.data_ack = 1'b0;
    #12 rst = 1'b1;
    #1;
    chk("rst_sel", {bus.s1, bus.s2, bus.s3}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_valid", bus.data_valid, 0);
`ifdef MUX_SCAN_PARITY_EN
    chk("rst_parity", bus.data_parity, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    scan(8'b0100_1101, 0, 1'b0, 1'b0);
    scan(8'b0100_1101, 5, 1'b0, 1'b0);
    scan(8'h3C, 2, 1'b1, 1'b0);
    scan(8'hE1, 1, 1'b0, 1'b1);
    scan(8'h7F, 0, 1'b0, 1'b0);
    scan(8'hA5, 1, 1'b0, 1'b0);
    @(negedge clk);
    mux_in = 8'h5A;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_data", bus.data, 0);
    chk("abort_valid", bus.data_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_sel", {bus.s1, bus.s2, bus.s3}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("abort_quiet", bus.data_valid, 0);
    end
    scan(8'h96, 0, 1'b0, 1'b0);
    repeat (12) scan(8'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
